// File: rtl/prbs_chk_pkg.sv
// Shared types and default parameters for the 16-lane PRBS receive checker.
package prbs_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2
    } chk_state_t;

    localparam int          N_LANES_DEF  = 16;
    localparam int          N_PRBS_DEF   = 32;
    localparam logic [31:0] EQN_DEF      = 32'h0010_0002;
    localparam int          CNT_W_DEF    = 32;
    localparam int          WIN_LEN_DEF  = 256;
    localparam int          LOSS_THR_DEF = 64;

endpackage

// File: rtl/prbs_lane_chk.sv
// One lane of the PRBS checker: received-bit history plus tap-parity predictor.
// The predictor only looks at received bits, so it re-synchronises on its own after any error.
module prbs_lane_chk
    import prbs_chk_pkg::*;
#(
    parameter int                N_PRBS = N_PRBS_DEF,
    parameter logic [N_PRBS-1:0] EQN    = N_PRBS'(EQN_DEF)
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic din,
    output logic err
);

    logic [N_PRBS-1:0] hist_r;

    function automatic logic tap_parity(input logic [N_PRBS-1:0] h);
        return ^(h & EQN);
    endfunction

    assign err = din ^ tap_parity(hist_r);

    // Received-bit history, newest bit in position 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_r <= {N_PRBS{1'b0}};
        end else if (shift_en) begin
            hist_r <= {hist_r[N_PRBS-2:0], din};
        end else begin
            hist_r <= hist_r;
        end
    end

endmodule

// File: rtl/prbs_checker_16l.sv
// Receive-side checker for the 16-lane PRBS bank: per-lane predictors, lock FSM,
// loss-of-lock window and saturating error/bit counters, all in the clk_prbsgen domain.
module prbs_checker_16l
    import prbs_chk_pkg::*;
#(
    parameter int                N_LANES  = N_LANES_DEF,
    parameter int                N_PRBS   = N_PRBS_DEF,
    parameter logic [N_PRBS-1:0] EQN      = N_PRBS'(EQN_DEF),
    parameter int                CNT_W    = CNT_W_DEF,
    parameter int                WIN_LEN  = WIN_LEN_DEF,
    parameter int                LOSS_THR = LOSS_THR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               chk_en,
    input  logic               din_valid,
    input  logic [N_LANES-1:0] din,
    input  logic               clr_cnt,
    output logic               locked,
    output logic [1:0]         state,
    output logic [N_LANES-1:0] err_lanes,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]   bit_cnt
);

    localparam int PC_W = $clog2(N_LANES + 1);
    localparam int FC_W = $clog2(N_PRBS);
    localparam int WC_W = $clog2(WIN_LEN);
    localparam int WE_W = $clog2(LOSS_THR + N_LANES + 1);

    chk_state_t         state_r;
    chk_state_t         state_nxt_s;
    logic [FC_W-1:0]    fill_cnt_r;
    logic [FC_W-1:0]    fill_cnt_nxt_s;
    logic [WC_W-1:0]    win_cyc_r;
    logic [WC_W-1:0]    win_cyc_nxt_s;
    logic [WE_W-1:0]    win_err_r;
    logic [WE_W-1:0]    win_err_nxt_s;
    logic [WE_W-1:0]    win_sum_s;
    logic [N_LANES-1:0] err_s;
    logic [PC_W-1:0]    pop_s;
    logic               shift_en_s;
    logic               cnt_en_s;
    logic               loss_s;
    logic               locked_r;
    logic [N_LANES-1:0] err_lanes_r;
    logic [CNT_W-1:0]   err_cnt_r;
    logic [CNT_W-1:0]   bit_cnt_r;

    function automatic logic [PC_W-1:0] popcount(input logic [N_LANES-1:0] v);
        logic [PC_W-1:0] acc;
        acc = {PC_W{1'b0}};
        for (int i = 0; i < N_LANES; i++) begin
            acc = acc + PC_W'(v[i]);
        end
        return acc;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        prbs_lane_chk #(
            .N_PRBS (N_PRBS),
            .EQN    (EQN)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .shift_en (shift_en_s),
            .din      (din[g]),
            .err      (err_s[g])
        );
    end

    // Histories advance in FILL and CHECK; only CHECK samples are scored
    assign shift_en_s = chk_en & din_valid & (state_r != IDLE);
    assign cnt_en_s   = chk_en & din_valid & (state_r == CHECK);
    assign pop_s      = popcount(err_s);
    assign win_sum_s  = win_err_r + WE_W'(pop_s);
    assign loss_s     = cnt_en_s & (win_sum_s >= WE_W'(LOSS_THR));

    // Next-state, fill-count and window logic
    always_comb begin
        state_nxt_s    = state_r;
        fill_cnt_nxt_s = fill_cnt_r;
        win_cyc_nxt_s  = win_cyc_r;
        win_err_nxt_s  = win_err_r;
        if (!chk_en) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = FILL;
                end
                FILL: begin
                    if (din_valid) begin
                        if (fill_cnt_r == FC_W'(N_PRBS - 1)) begin
                            state_nxt_s = CHECK;
                        end else begin
                            fill_cnt_nxt_s = fill_cnt_r + FC_W'(1);
                        end
                    end else begin
                        fill_cnt_nxt_s = fill_cnt_r;
                    end
                end
                CHECK: begin
                    if (din_valid) begin
                        if (loss_s) begin
                            state_nxt_s = FILL;
                        end else if (win_cyc_r == WC_W'(WIN_LEN - 1)) begin
                            win_cyc_nxt_s = {WC_W{1'b0}};
                            win_err_nxt_s = {WE_W{1'b0}};
                        end else begin
                            win_cyc_nxt_s = win_cyc_r + WC_W'(1);
                            win_err_nxt_s = (win_sum_s >= WE_W'(LOSS_THR)) ? WE_W'(LOSS_THR)
                                                                           : win_sum_s;
                        end
                    end else begin
                        win_cyc_nxt_s = win_cyc_r;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
        // Every (re)entry into FILL or CHECK starts from a clean count
        if (state_nxt_s != FILL) begin
            fill_cnt_nxt_s = {FC_W{1'b0}};
        end else begin
            fill_cnt_nxt_s = fill_cnt_nxt_s;
        end
        if (state_nxt_s != CHECK) begin
            win_cyc_nxt_s = {WC_W{1'b0}};
            win_err_nxt_s = {WE_W{1'b0}};
        end else begin
            win_cyc_nxt_s = win_cyc_nxt_s;
        end
    end

    // FSM, fill counter, window and lock registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            fill_cnt_r <= {FC_W{1'b0}};
            win_cyc_r  <= {WC_W{1'b0}};
            win_err_r  <= {WE_W{1'b0}};
            locked_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            fill_cnt_r <= fill_cnt_nxt_s;
            win_cyc_r  <= win_cyc_nxt_s;
            win_err_r  <= win_err_nxt_s;
            locked_r   <= (state_nxt_s == CHECK);
        end
    end

    // Per-lane flags and saturating totals, one cycle behind the sampled word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_lanes_r <= {N_LANES{1'b0}};
            err_cnt_r   <= {CNT_W{1'b0}};
            bit_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (cnt_en_s) begin
                err_lanes_r <= err_s;
            end else begin
                err_lanes_r <= {N_LANES{1'b0}};
            end
            if (clr_cnt) begin
                err_cnt_r <= {CNT_W{1'b0}};
                bit_cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_en_s) begin
                err_cnt_r <= sat_add(err_cnt_r, CNT_W'(pop_s));
                bit_cnt_r <= sat_add(bit_cnt_r, CNT_W'(N_LANES));
            end else begin
                err_cnt_r <= err_cnt_r;
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    assign locked    = locked_r;
    assign state     = state_r;
    assign err_lanes = err_lanes_r;
    assign err_cnt   = err_cnt_r;
    assign bit_cnt   = bit_cnt_r;

endmodule

// File: tb/tb_prbs_checker_16l.sv
// Self-checking bench for prbs_checker_16l: full-width instance plus an 8-bit-counter instance,
// both scored against a bit-history reference model of the checker rules.
module tb_prbs_checker_16l;

    localparam int          NL   = 16;
    localparam int          NP   = 32;
    localparam logic [31:0] TAPS = 32'h0010_0002;
    localparam int          WIN  = 256;
    localparam int          THR  = 64;
    localparam int          RING = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        chk_en;
    logic        din_valid;
    logic [15:0] din;
    logic        clr_cnt;
    logic        locked,  locked8;
    logic [1:0]  state,   state8;
    logic [15:0] err_lanes, err_lanes8;
    logic [31:0] err_cnt, bit_cnt;
    logic [7:0]  err_cnt8, bit_cnt8;

    always #5 clk = ~clk;

    prbs_checker_16l dut (
        .clk(clk), .rst(rst), .chk_en(chk_en), .din_valid(din_valid), .din(din),
        .clr_cnt(clr_cnt), .locked(locked), .state(state), .err_lanes(err_lanes),
        .err_cnt(err_cnt), .bit_cnt(bit_cnt)
    );

    prbs_checker_16l #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .chk_en(chk_en), .din_valid(din_valid), .din(din),
        .clr_cnt(clr_cnt), .locked(locked8), .state(state8), .err_lanes(err_lanes8),
        .err_cnt(err_cnt8), .bit_cnt(bit_cnt8)
    );

    // reference model: received bits per lane, index = arrival order since reset
    bit          rx_bits [NL][RING];
    int          rx_n;
    bit          tx_bits [NL][RING];
    int          tx_n;
    int          m_state, m_fill, m_wcyc, m_werr;
    longint      m_err, m_bit, m_err8, m_bit8;
    logic [15:0] m_lanes;
    int          passed = 0;
    int          total  = 0;

    function automatic bit rx_pred(int l);
        bit p = 1'b0;
        for (int k = 0; k < NP; k++)
            if (TAPS[k] && (rx_n - 1 - k) >= 0) p ^= rx_bits[l][(rx_n - 1 - k) % RING];
        return p;
    endfunction

    function automatic logic [117:0] dut_vec();
        return {state, locked, err_lanes, err_cnt, bit_cnt, err_cnt8, bit_cnt8,
                state8, locked8, err_lanes8};
    endfunction

    function automatic logic [117:0] model_vec();
        logic lk;
        lk = (m_state == 2) ? 1'b1 : 1'b0;
        return {2'(m_state), lk, m_lanes, 32'(m_err), 32'(m_bit), 8'(m_err8), 8'(m_bit8),
                2'(m_state), lk, m_lanes};
    endfunction

    task automatic model_reset();
        rx_n = 0; m_state = 0; m_fill = 0; m_wcyc = 0; m_werr = 0;
        m_err = 0; m_bit = 0; m_err8 = 0; m_bit8 = 0; m_lanes = 16'h0000;
    endtask

    task automatic seed_tx();
        logic [31:0] s;
        for (int l = 0; l < NL; l++) begin
            s = 32'h1357_9BDF ^ (32'(l) * 32'h0101_0101);
            for (int k = 0; k < NP; k++) tx_bits[l][NP - 1 - k] = s[k];
        end
        tx_n = NP;
    endtask

    task automatic gen_word(output logic [15:0] w);
        for (int l = 0; l < NL; l++) begin
            bit b;
            b = 1'b0;
            for (int k = 0; k < NP; k++)
                if (TAPS[k]) b ^= tx_bits[l][(tx_n - 1 - k) % RING];
            w[l] = b;
        end
        for (int l = 0; l < NL; l++) tx_bits[l][tx_n % RING] = w[l];
        tx_n++;
    endtask

    task automatic model_step();
        bit          act;
        logic [15:0] e;
        int          pc;
        act = chk_en && din_valid;
        e   = 16'h0000;
        pc  = 0;
        if (act && m_state != 0) begin
            for (int l = 0; l < NL; l++) e[l] = din[l] ^ rx_pred(l);
            for (int l = 0; l < NL; l++) rx_bits[l][rx_n % RING] = din[l];
            rx_n++;
        end
        if (act && m_state == 2) begin
            pc      = $countones(e);
            m_lanes = e;
            m_err   = (m_err + pc > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_err + pc;
            m_bit   = (m_bit + NL > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_bit + NL;
            m_err8  = (m_err8 + pc > 255) ? 255 : m_err8 + pc;
            m_bit8  = (m_bit8 + NL > 255) ? 255 : m_bit8 + NL;
        end else begin
            m_lanes = 16'h0000;
        end
        if (clr_cnt) begin
            m_err = 0; m_bit = 0; m_err8 = 0; m_bit8 = 0;
        end
        if (!chk_en) begin
            m_state = 0; m_fill = 0; m_wcyc = 0; m_werr = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_fill = 0;
        end else if (m_state == 1) begin
            if (din_valid) begin
                m_fill++;
                if (m_fill == NP) begin
                    m_state = 2; m_wcyc = 0; m_werr = 0;
                end
            end
        end else if (din_valid) begin
            if (m_werr + pc >= THR) begin
                m_state = 1; m_fill = 0; m_wcyc = 0; m_werr = 0;
            end else begin
                m_wcyc++;
                m_werr += pc;
                if (m_wcyc == WIN) begin
                    m_wcyc = 0; m_werr = 0;
                end
            end
        end
    endtask

    task automatic tick(input bit v, input logic [15:0] d);
        din_valid = v;
        din       = d;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; chk_en = 1'b0; din_valid = 1'b0; din = 16'h0000; clr_cnt = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({state, locked, err_lanes, err_cnt, bit_cnt} !== 83'h0)
            $display("FAIL reset_outputs got %h required 0", {state, locked, err_lanes, err_cnt, bit_cnt});
        else passed++;
        total++;
        if ({state8, locked8, err_lanes8, err_cnt8, bit_cnt8} !== 35'h0)
            $display("FAIL reset_outputs8 got %h required 0", {state8, locked8, err_lanes8, err_cnt8, bit_cnt8});
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_lock();
        logic [15:0] w;
        seed_tx();
        chk_en = 1'b1;
        tick(1'b0, 16'h0000);
        total++;
        if (state !== 2'd1 || locked !== 1'b0) $display("FAIL enter_fill got state=%0d locked=%0b required 1/0", state, locked);
        else passed++;
        for (int i = 0; i < NP + 1000; i++) begin
            gen_word(w);
            tick(1'b1, w);
            total++;
            if (dut_vec() !== model_vec()) $display("FAIL lock_cycle%0d got %h required %h", i, dut_vec(), model_vec());
            else passed++;
            if (i == NP - 2) begin
                total++;
                if (locked !== 1'b0) $display("FAIL early_lock got %0b required 0", locked);
                else passed++;
            end
            if (i == NP - 1) begin
                total++;
                if (locked !== 1'b1 || state !== 2'd2) $display("FAIL lock_at_32 got locked=%0b state=%0d required 1/2", locked, state);
                else passed++;
            end
        end
        total++;
        if (err_cnt !== 32'd0 || bit_cnt !== 32'd16000)
            $display("FAIL clean_1000 got err=%0d bits=%0d required 0/16000", err_cnt, bit_cnt);
        else passed++;
    endtask

    task automatic test_inject();
        logic [15:0] w;
        gen_word(w);
        tick(1'b1, w ^ 16'h0020);
        total++;
        if (err_lanes !== 16'h0020) $display("FAIL inject_lanes got %h required 0020", err_lanes);
        else passed++;
        for (int i = 0; i < 30; i++) begin
            gen_word(w);
            tick(1'b1, w);
            total++;
            if (dut_vec() !== model_vec()) $display("FAIL inject_cycle%0d got %h required %h", i, dut_vec(), model_vec());
            else passed++;
        end
        total++;
        if (err_cnt !== 32'd3 || locked !== 1'b1) $display("FAIL inject_total got err=%0d locked=%0b required 3/1", err_cnt, locked);
        else passed++;
    endtask

    task automatic test_loss();
        logic [15:0] w;
        int          guard;
        guard = 0;
        while (m_state == 2 && guard < 2 * WIN) begin
            tick(1'b1, 16'($urandom()));
            guard++;
            total++;
            if (dut_vec() !== model_vec()) $display("FAIL loss_cycle%0d got %h required %h", guard, dut_vec(), model_vec());
            else passed++;
        end
        total++;
        if (state !== 2'd1 || locked !== 1'b0 || guard >= WIN)
            $display("FAIL loss_of_lock got state=%0d locked=%0b after %0d cycles required 1/0 within window", state, locked, guard);
        else passed++;
        for (int i = 0; i < NP; i++) begin
            gen_word(w);
            tick(1'b1, w);
            total++;
            if (dut_vec() !== model_vec()) $display("FAIL relock_cycle%0d got %h required %h", i, dut_vec(), model_vec());
            else passed++;
            if (i == NP - 2) begin
                total++;
                if (locked !== 1'b0) $display("FAIL relock_early got %0b required 0", locked);
                else passed++;
            end
        end
        total++;
        if (locked !== 1'b1) $display("FAIL relock_32 got %0b required 1", locked);
        else passed++;
    endtask

    task automatic test_clr();
        logic [15:0] w;
        gen_word(w);
        clr_cnt = 1'b1;
        tick(1'b1, w ^ 16'h0100);
        clr_cnt = 1'b0;
        total++;
        if (err_cnt !== 32'd0 || bit_cnt !== 32'd0 || state !== 2'd2 || locked !== 1'b1)
            $display("FAIL clr_same_cycle got err=%0d bits=%0d state=%0d locked=%0b required 0/0/2/1", err_cnt, bit_cnt, state, locked);
        else passed++;
        for (int i = 0; i < 25; i++) begin
            gen_word(w);
            tick(1'b1, w);
            total++;
            if (dut_vec() !== model_vec()) $display("FAIL clr_cycle%0d got %h required %h", i, dut_vec(), model_vec());
            else passed++;
        end
        total++;
        if (err_cnt !== 32'd2 || bit_cnt !== 32'd400)
            $display("FAIL clr_after got err=%0d bits=%0d required 2/400", err_cnt, bit_cnt);
        else passed++;
    endtask

    task automatic test_saturate();
        logic [15:0] w;
        gen_word(w);
        clr_cnt = 1'b1;
        tick(1'b1, w);
        clr_cnt = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick(1'b1, 16'($urandom()));
            total++;
            if (dut_vec() !== model_vec()) $display("FAIL sat_cycle%0d got %h required %h", i, dut_vec(), model_vec());
            else passed++;
        end
        total++;
        if (err_cnt8 !== 8'hFF || bit_cnt8 !== 8'hFF)
            $display("FAIL sat_8bit got err=%0d bits=%0d required 255/255", err_cnt8, bit_cnt8);
        else passed++;
    endtask

    task automatic test_gaps_and_async_reset();
        logic [15:0] w;
        chk_en = 1'b0;
        tick(1'b0, 16'h0000);
        chk_en = 1'b1;
        tick(1'b0, 16'h0000);
        for (int i = 0; i < NP; i++) begin
            gen_word(w);
            tick(1'b1, w);
        end
        clr_cnt = 1'b1;
        tick(1'b0, 16'h0000);
        clr_cnt = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i % 3 == 0) begin
                gen_word(w);
                tick(1'b1, w);
            end else begin
                tick(1'b0, 16'($urandom()));
            end
            total++;
            if (dut_vec() !== model_vec()) $display("FAIL gap_cycle%0d got %h required %h", i, dut_vec(), model_vec());
            else passed++;
        end
        total++;
        if (err_cnt !== 32'd0 || bit_cnt !== 32'd1600 || locked !== 1'b1)
            $display("FAIL gap_totals got err=%0d bits=%0d locked=%0b required 0/1600/1", err_cnt, bit_cnt, locked);
        else passed++;
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if ({state, locked, err_lanes, err_cnt, bit_cnt} !== 83'h0)
            $display("FAIL async_reset got %h required 0", {state, locked, err_lanes, err_cnt, bit_cnt});
        else passed++;
        total++;
        if ({state8, locked8, err_lanes8, err_cnt8, bit_cnt8} !== 35'h0)
            $display("FAIL async_reset8 got %h required 0", {state8, locked8, err_lanes8, err_cnt8, bit_cnt8});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_inject();
        test_loss();
        test_clr();
        test_saturate();
        test_gaps_and_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
